mb_luma_rd_sched: RTL and testbench

//  Read scheduler that feeds the H.264 macroblock luma fetch stage. On fetch request it issues 64 word reads
//  (16 rows x 4 words) for the 16x16 luma MB at (mb_x,mb_y) to the frame-buffer bus port.

---
 rtl/mb_luma_rd_sched.sv | 141 ++++++++++++++
 tb/tb_mb_luma_rd_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_luma_rd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mb_luma_rd_sched : issues the 64 word reads of one 16x16 luma MB in raster  |
// | order with bounded outstanding reads; forwards in-order data.  Rev 1.0      |
// +----------------------------------------------------------------------------+
module mb_luma_rd_sched #(
   parameter int ADDR_W   = 32,
   parameter int MAX_OUTS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              h264_reset,
   input  logic [ADDR_W-1:0] frame_base_i,
   input  logic [11:0]       frame_width_i,
   input  logic              fetch_req_i,
   input  logic [5:0]        mb_x_i,
   input  logic [5:0]        mb_y_i,
   output logic              rd_req_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic              rd_gnt_i,
   input  logic [31:0]       rd_rdata_i,
   input  logic              rd_rvalid_i,
   output logic [31:0]       data_word_o,
   output logic              data_valid_o,
   output logic              busy_o,
   output logic              mb_done_o,
   output logic              err_o
);

   localparam logic [6:0] C_WORDS    = 7'd64;
   localparam logic [3:0] C_MAX_OUTS = 4'(MAX_OUTS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CALC  = 3'd1,
      S_ISSUE = 3'd2,
      S_DRAIN = 3'd3,
      S_FLUSH = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [6:0]        issued_q, issued_d;
   logic [6:0]        ret_q, ret_d;
   logic [3:0]        outs_q, outs_d;
   logic [ADDR_W-1:0] row_q, row_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              grant;
   logic              ret_hit;
   logic [ADDR_W-1:0] mb_base;

   assign mb_base = frame_base_i
                  + ((ADDR_W'(mb_y_i) * ADDR_W'(frame_width_i)) << 4)
                  + (ADDR_W'(mb_x_i) << 4);

   // Request and forward are masked during the soft-reset cycle so nothing is granted or delivered.
   assign rd_req_o     = !h264_reset && (state_q == S_ISSUE) && (issued_q < C_WORDS)
                       && (outs_q < C_MAX_OUTS);
   assign rd_addr_o    = row_q + ADDR_W'({issued_q[1:0], 2'b00});
   assign grant        = rd_req_o && rd_gnt_i;
   assign ret_hit      = rd_rvalid_i && (outs_q != 4'd0);
   assign data_valid_o = ret_hit && !h264_reset && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
   assign data_word_o  = rd_rdata_i;
   assign busy_o       = (state_q != S_IDLE);
   assign mb_done_o    = done_q;
   assign err_o        = err_q;

   always_comb begin
      state_d  = state_q;
      issued_d = issued_q;
      ret_d    = ret_q;
      row_d    = row_q;
      done_d   = 1'b0;
      err_d    = err_q | (rd_rvalid_i && (outs_q == 4'd0));
      outs_d   = outs_q + 4'(grant) - 4'(ret_hit);

      if (h264_reset) begin
         issued_d = '0;
         ret_d    = '0;
         row_d    = '0;
         outs_d   = outs_q - 4'(ret_hit);
         state_d  = (outs_q != 4'd0) ? S_FLUSH : S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (fetch_req_i) state_d = S_CALC;
            end
            S_CALC: begin
               row_d    = mb_base;
               issued_d = '0;
               ret_d    = '0;
               state_d  = S_ISSUE;
            end
            S_ISSUE: begin
               if (grant) begin
                  issued_d = issued_q + 7'd1;
                  if (issued_q[1:0] == 2'd3) row_d = row_q + ADDR_W'(frame_width_i);
                  if (issued_q == C_WORDS - 7'd1) state_d = S_DRAIN;
               end
               if (data_valid_o) ret_d = ret_q + 7'd1;
            end
            S_DRAIN: begin
               if (data_valid_o) begin
                  ret_d = ret_q + 7'd1;
                  if (ret_q == C_WORDS - 7'd1) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            S_FLUSH: begin
               if (outs_d == 4'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         issued_q <= '0;
         ret_q    <= '0;
         outs_q   <= '0;
         row_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         issued_q <= issued_d;
         ret_q    <= ret_d;
         outs_q   <= outs_d;
         row_q    <= row_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mb_luma_rd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mb_luma_rd_sched : random bus responder + scoreboard for the MB luma     |
// | read scheduler. Rev 1.0                                                    |
// +----------------------------------------------------------------------------+
module tb_mb_luma_rd_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        h264_reset = 1'b0;
   logic [31:0] frame_base_i = '0;
   logic [11:0] frame_width_i = '0;
   logic        fetch_req_i = 1'b0;
   logic [5:0]  mb_x_i = '0;
   logic [5:0]  mb_y_i = '0;
   logic        rd_req_o;
   logic [31:0] rd_addr_o;
   logic        rd_gnt_i = 1'b0;
   logic [31:0] rd_rdata_i = '0;
   logic        rd_rvalid_i = 1'b0;
   logic [31:0] data_word_o;
   logic        data_valid_o;
   logic        busy_o;
   logic        mb_done_o;
   logic        err_o;

   mb_luma_rd_sched #(.ADDR_W(32), .MAX_OUTS(4)) dut (
      .clk(clk), .rst_n(rst_n), .h264_reset(h264_reset),
      .frame_base_i(frame_base_i), .frame_width_i(frame_width_i),
      .fetch_req_i(fetch_req_i), .mb_x_i(mb_x_i), .mb_y_i(mb_y_i),
      .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_gnt_i(rd_gnt_i),
      .rd_rdata_i(rd_rdata_i), .rd_rvalid_i(rd_rvalid_i),
      .data_word_o(data_word_o), .data_valid_o(data_valid_o),
      .busy_o(busy_o), .mb_done_o(mb_done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          due;
   } pend_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   pend_t       pend[$];
   int          cyc = 0;
   int          m_outs = 0;
   bit          flushing = 1'b0;
   int          gnt_mode = 1;   // 0 random, 1 always, 2 never
   int          rv_mode = 1;    // 0 random delay, 1 next cycle, 2 withheld
   bit          stray_req = 1'b0;
   int          mon_cnt = 0;
   int          done_cnt = 0;
   bit          exp_done = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Bus responder: decides grant/return a half cycle ahead of each rising edge.
   initial begin : drv
      logic [31:0] d;
      int          dl;
      forever begin
         @(negedge clk); #1;
         cyc++;
         rd_rvalid_i = 1'b0;
         rd_rdata_i  = $urandom;
         if (!rst_n) begin
            rd_gnt_i = 1'b0;
         end else begin
            if (h264_reset && m_outs > 0) flushing = 1'b1;
            if (stray_req) begin
               rd_rvalid_i = 1'b1;
               stray_req   = 1'b0;
            end else if (rv_mode != 2 && pend.size() > 0 && pend[0].due <= cyc &&
                         (rv_mode == 1 || $urandom_range(0, 3) != 0)) begin
               rd_rvalid_i = 1'b1;
               rd_rdata_i  = pend[0].data;
               void'(pend.pop_front());
               if (!flushing && !h264_reset) exp_data.push_back(rd_rdata_i);
               m_outs--;
            end
            if (m_outs == 0) flushing = 1'b0;
            case (gnt_mode)
               1:       rd_gnt_i = 1'b1;
               2:       rd_gnt_i = 1'b0;
               default: rd_gnt_i = ($urandom_range(0, 3) != 0);
            endcase
            if (rd_req_o && rd_gnt_i) begin
               d  = $urandom;
               dl = (rv_mode == 1) ? 1 : 1 + $urandom_range(0, 3);
               pend.push_back('{data: d, due: cyc + dl});
               m_outs++;
            end
         end
      end
   end

   initial begin : mon
      logic [31:0] e;
      forever begin
         @(negedge clk); #2;
         if (!rst_n) begin
            exp_done = 1'b0;
         end else begin
            if (exp_done || mb_done_o) check("mb_done", mb_done_o, exp_done);
            if (mb_done_o) done_cnt++;
            exp_done = 1'b0;
            if (rd_req_o && rd_gnt_i) begin
               if (exp_addr.size() == 0) check("grant_unexpected", rd_req_o, 0);
               else check("rd_addr", rd_addr_o, exp_addr.pop_front());
            end
            if (data_valid_o || exp_data.size() > 0) begin
               if (exp_data.size() == 0) begin
                  check("data_valid_unexpected", data_valid_o, 0);
               end else begin
                  e = exp_data.pop_front();
                  check("data_valid", data_valid_o, 1);
                  if (data_valid_o) check("data_word", data_word_o, e);
               end
            end
            if (data_valid_o) begin
               mon_cnt++;
               if (mon_cnt == 64) begin
                  mon_cnt  = 0;
                  exp_done = 1'b1;
               end
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk); #3;
      end
   endtask

   // Word (r,k) of MB (x,y) sits at pixel row 16y+r, pixel column 16x+4k.
   task automatic push_mb(input int x, input int y);
      logic [31:0] a;
      for (int r = 0; r < 16; r++) begin
         for (int k = 0; k < 4; k++) begin
            a = frame_base_i + 32'(16 * y + r) * 32'(frame_width_i) + 32'(16 * x + 4 * k);
            exp_addr.push_back(a);
         end
      end
   endtask

   task automatic start_mb(input int x, input int y, input string tag);
      push_mb(x, y);
      mb_x_i      = 6'(x);
      mb_y_i      = 6'(y);
      fetch_req_i = 1'b1;
      tick();
      fetch_req_i = 1'b0;
      check({tag, "_busy_start"}, busy_o, 1);
   endtask

   task automatic wait_mb(input string tag);
      int d0;
      int t;
      d0 = done_cnt;
      t  = 0;
      while (done_cnt == d0 && t < 3000) begin
         tick();
         t++;
      end
      check({tag, "_done_seen"}, (done_cnt != d0), 1);
      check({tag, "_busy_end"}, busy_o, 0);
      check({tag, "_addr_left"}, exp_addr.size(), 0);
   endtask

   task automatic run_mb(input int x, input int y, input string tag);
      start_mb(x, y, tag);
      wait_mb(tag);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int t;
      #1;
      check("rst_req", rd_req_o, 0);
      check("rst_addr", rd_addr_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_err", err_o, 0);
      check("rst_done", mb_done_o, 0);
      check("rst_dv", data_valid_o, 0);
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // T1: raster order, grant every cycle, return one cycle later
      frame_base_i  = 32'h1000;
      frame_width_i = 12'd64;
      gnt_mode = 1; rv_mode = 1;
      run_mb(0, 0, "T1");

      // T2: interior MB with random grant/return timing
      gnt_mode = 0; rv_mode = 0;
      run_mb(2, 1, "T2");

      // T4: steady grant+return in the same cycle, other width and base
      frame_base_i  = $urandom & 32'hFFFF_FFFC;
      frame_width_i = 12'd128;
      gnt_mode = 1; rv_mode = 1;
      run_mb(3, 2, "T4");

      for (int i = 0; i < 3; i++) begin
         frame_base_i  = $urandom & 32'hFFFF_FFFC;
         frame_width_i = 12'(16 * $urandom_range(1, 255));
         gnt_mode = 0; rv_mode = 0;
         run_mb($urandom_range(0, 63), $urandom_range(0, 63), "TR");
      end

      // T3: stall mid-row, then saturate outstanding reads
      frame_base_i  = 32'h0002_0000;
      frame_width_i = 12'd320;
      gnt_mode = 1; rv_mode = 2;
      start_mb(1, 0, "T3");
      t = 0;
      while (m_outs < 2 && t < 50) begin tick(); t++; end
      gnt_mode = 2;
      tick();
      for (int i = 0; i < 10; i++) begin
         check("T3_req_held", rd_req_o, 1);
         check("T3_addr_stable", rd_addr_o, exp_addr[0]);
         tick();
      end
      gnt_mode = 1;
      t = 0;
      while (m_outs < 4 && t < 50) begin tick(); t++; end
      tick();
      for (int i = 0; i < 3; i++) begin
         check("T3_req_saturated", rd_req_o, 0);
         tick();
      end
      gnt_mode = 0; rv_mode = 0;
      wait_mb("T3");

      // T5: soft reset with three reads outstanding
      gnt_mode = 1; rv_mode = 2;
      start_mb(0, 1, "T5");
      t = 0;
      while (m_outs < 3 && t < 50) begin tick(); t++; end
      gnt_mode = 2;
      tick();
      h264_reset = 1'b1;
      tick();
      h264_reset = 1'b0;
      exp_addr.delete();
      mon_cnt = 0;
      check("T5_flush_busy", busy_o, 1);
      check("T5_flush_req", rd_req_o, 0);
      t = 0;
      rv_mode = 1;
      while (busy_o && t < 100) begin tick(); t++; end
      check("T5_back_idle", busy_o, 0);
      gnt_mode = 0; rv_mode = 0;
      run_mb(4, 3, "T5b");

      // T6: stray return in IDLE, then async reset mid-issue
      stray_req = 1'b1;
      tick();
      check("T6_stray_dv", data_valid_o, 0);
      tick();
      check("T6_err_set", err_o, 1);
      h264_reset = 1'b1;
      tick();
      h264_reset = 1'b0;
      tick();
      check("T6_err_sticky", err_o, 1);
      gnt_mode = 1; rv_mode = 2;
      start_mb(5, 5, "T6");
      tick(2);
      #1;
      rst_n = 1'b0;
      #1;
      check("T6_arst_req", rd_req_o, 0);
      check("T6_arst_busy", busy_o, 0);
      check("T6_arst_err", err_o, 0);
      check("T6_arst_addr", rd_addr_o, 0);
      check("T6_arst_done", mb_done_o, 0);
      pend.delete();
      exp_addr.delete();
      exp_data.delete();
      m_outs   = 0;
      flushing = 1'b0;
      mon_cnt  = 0;
      tick(2);
      rst_n = 1'b1;
      tick();
      gnt_mode = 0; rv_mode = 0;
      run_mb(7, 9, "T6b");

      tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
